// File: rtl/de_ex_pkg.sv
// Shared constants and control-word layout for the decode/execute register.
// Consumed by de_ex_hazard and de_ex_pipe.
package de_ex_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_DEF  = 24;

    localparam int CTRL_MEM_OP_LSB = 0;
    localparam int CTRL_ALUOP_LSB  = 3;
    localparam int CTRL_ALUSUB_BIT = 7;
    localparam int CTRL_CSROP_LSB  = 8;
    localparam int CTRL_MDOP_LSB   = 11;
    localparam int CTRL_MEM_EN_BIT = 14;
    localparam int CTRL_WR_MEM_BIT = 15;
    localparam int CTRL_CSR_RD_BIT = 16;
    localparam int CTRL_CSR_WR_BIT = 17;

    typedef struct packed {
        logic [5:0] rsvd;
        logic       csr_wr;
        logic       csr_rd;
        logic       wr_mem;
        logic       mem_en;
        logic [2:0] md_op;
        logic [2:0] csrop;
        logic       aluop_sub;
        logic [3:0] aluop;
        logic [2:0] mem_op;
    } ctrl_t;

endpackage

// File: rtl/de_ex_hazard.sv
// Combinational load-use comparator between the execute-slot load and
// the instruction currently in decode.
module de_ex_hazard
    import de_ex_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_load,
    input  logic                 ex_wr_reg,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    output logic                 hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign w_rs2_hit = id_rs2_used & (id_rs2 == ex_rd);

    // ex_wr_reg is never set for rd 0, so x0 cannot interlock
    assign hazard = ex_valid & ex_load & ex_wr_reg & id_valid
                  & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/de_ex_pipe.sv
// Decode-to-execute pipeline register with load-use interlock,
// flush/hold/bubble priority and optional DE_EX_PERF_EN counters.
module de_ex_pipe
    import de_ex_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_DEF,
    parameter int NSTALL = 4
) (
    input  logic                 clk,
    input  logic                 cpurst,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_op1,
    input  logic [XLEN-1:0]      in_op2,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic                 in_load,
    input  logic                 in_wr_reg,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    input  logic                 flush,
    input  logic [NSTALL-1:0]    stall_vec,
    output logic                 hazard_stall,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_wdata,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 out_load,
    output logic                 out_wr_reg,
    output logic [REG_IDX_W-1:0] out_rd
`ifdef DE_EX_PERF_EN
    ,
    output logic [31:0]          bubble_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    logic                 r_valid;
    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_op1;
    logic [XLEN-1:0]      r_op2;
    logic [XLEN-1:0]      r_wdata;
    logic [CTRL_W-1:0]    r_ctrl;
    logic                 r_load;
    logic                 r_wr_reg;
    logic [REG_IDX_W-1:0] r_rd;

    logic w_hold;
    logic w_hazard;

    assign w_hold = |stall_vec;

    de_ex_hazard u_hazard (
        .ex_valid    (r_valid),
        .ex_load     (r_load),
        .ex_wr_reg   (r_wr_reg),
        .ex_rd       (r_rd),
        .id_valid    (in_valid),
        .id_rs1      (in_rs1),
        .id_rs2      (in_rs2),
        .id_rs1_used (in_rs1_used),
        .id_rs2_used (in_rs2_used),
        .hazard      (w_hazard)
    );

    assign hazard_stall = w_hazard;
    assign in_ready     = ~w_hold & ~w_hazard;

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_wdata  <= '0;
            r_ctrl   <= '0;
            r_load   <= 1'b0;
            r_wr_reg <= 1'b0;
            r_rd     <= '0;
        end else if (flush || (!w_hold && w_hazard)) begin
            // flush and bubble both kill the slot but keep the data fields
            r_valid  <= 1'b0;
            r_load   <= 1'b0;
            r_wr_reg <= 1'b0;
        end else if (!w_hold) begin
            r_valid  <= in_valid;
            r_pc     <= in_pc;
            r_op1    <= in_op1;
            r_op2    <= in_op2;
            r_wdata  <= in_wdata;
            r_ctrl   <= in_ctrl;
            r_load   <= in_valid & in_load;
            r_wr_reg <= in_valid & in_wr_reg & (in_rd != '0);
            r_rd     <= in_rd;
        end
    end

    assign out_valid  = r_valid;
    assign out_pc     = r_pc;
    assign out_op1    = r_op1;
    assign out_op2    = r_op2;
    assign out_wdata  = r_wdata;
    assign out_ctrl   = r_ctrl;
    assign out_load   = r_load;
    assign out_wr_reg = r_wr_reg;
    assign out_rd     = r_rd;

`ifdef DE_EX_PERF_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_bubble;

    assign w_bubble = ~flush & ~w_hold & w_hazard;

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_hold && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_de_ex_pipe.sv
// Directed self-checking bench for de_ex_pipe.
// Counter checks are compiled in only with DE_EX_PERF_EN.
module tb_de_ex_pipe;

    logic        clk;
    logic        cpurst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] in_wdata;
    logic [23:0] in_ctrl;
    logic        in_load;
    logic        in_wr_reg;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        in_rs1_used;
    logic        in_rs2_used;
    logic        flush;
    logic [3:0]  stall_vec;
    logic        hazard_stall;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_wdata;
    logic [23:0] out_ctrl;
    logic        out_load;
    logic        out_wr_reg;
    logic [4:0]  out_rd;
`ifdef DE_EX_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    de_ex_pipe dut (
        .clk          (clk),
        .cpurst       (cpurst),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .in_wdata     (in_wdata),
        .in_ctrl      (in_ctrl),
        .in_load      (in_load),
        .in_wr_reg    (in_wr_reg),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rs1_used  (in_rs1_used),
        .in_rs2_used  (in_rs2_used),
        .flush        (flush),
        .stall_vec    (stall_vec),
        .hazard_stall (hazard_stall),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .out_wdata    (out_wdata),
        .out_ctrl     (out_ctrl),
        .out_load     (out_load),
        .out_wr_reg   (out_wr_reg),
        .out_rd       (out_rd)
`ifdef DE_EX_PERF_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cpurst      = 1'b1;
        in_valid    = 1'b1;
        in_pc       = 32'h55;
        in_op1      = 32'h11;
        in_op2      = 32'h22;
        in_wdata    = 32'h33;
        in_ctrl     = 24'h123456;
        in_load     = 1'b1;
        in_wr_reg   = 1'b1;
        in_rd       = 5'd9;
        in_rs1      = 5'd0;
        in_rs2      = 5'd0;
        in_rs1_used = 1'b0;
        in_rs2_used = 1'b0;
        flush       = 1'b0;
        stall_vec   = 4'b0000;

        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_wr", out_wr_reg, 0);
        chk("rst_load", out_load, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_ready", in_ready, 1);
`ifdef DE_EX_PERF_EN
        chk("rst_bcnt", bubble_cnt, 0);
        chk("rst_scnt", stall_cnt, 0);
`endif

        // plain capture
        cpurst    = 1'b0;
        in_pc     = 32'h100;
        in_op1    = 32'd5;
        in_op2    = 32'd6;
        in_wdata  = 32'hDEAD;
        in_ctrl   = 24'hABCDEF;
        in_load   = 1'b0;
        in_wr_reg = 1'b1;
        in_rd     = 5'd3;
        tick();
        chk("cap_valid", out_valid, 1);
        chk("cap_pc", out_pc, 32'h100);
        chk("cap_op1", out_op1, 5);
        chk("cap_op2", out_op2, 6);
        chk("cap_wdata", out_wdata, 32'hDEAD);
        chk("cap_ctrl", out_ctrl, 24'hABCDEF);
        chk("cap_rd", out_rd, 3);
        chk("cap_wr", out_wr_reg, 1);
        chk("cap_load", out_load, 0);

        // load-use: load x7 then use x7
        in_pc   = 32'h104;
        in_load = 1'b1;
        in_rd   = 5'd7;
        tick();
        chk("ld_load", out_load, 1);
        in_pc       = 32'h108;
        in_load     = 1'b0;
        in_rd       = 5'd8;
        in_rs1      = 5'd7;
        in_rs1_used = 1'b1;
        #1;
        chk("lu_haz", hazard_stall, 1);
        chk("lu_ready", in_ready, 0);
        tick();
        chk("lu_bub_valid", out_valid, 0);
        chk("lu_bub_load", out_load, 0);
        chk("lu_bub_pc", out_pc, 32'h104);
        chk("lu_haz_drop", hazard_stall, 0);
        tick();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_pc", out_pc, 32'h108);
        chk("lu_add_rd", out_rd, 8);
`ifdef DE_EX_PERF_EN
        chk("lu_bcnt", bubble_cnt, 1);
`endif

        // load to x0: no write, no hazard
        in_pc       = 32'h10C;
        in_load     = 1'b1;
        in_rd       = 5'd0;
        in_rs1_used = 1'b0;
        tick();
        chk("x0_wr", out_wr_reg, 0);
        chk("x0_load", out_load, 1);
        in_load     = 1'b0;
        in_rd       = 5'd5;
        in_rs1      = 5'd0;
        in_rs1_used = 1'b1;
        #1;
        chk("x0_haz", hazard_stall, 0);

        // load x4 then unused rs2 = 4
        in_pc       = 32'h110;
        in_load     = 1'b1;
        in_rd       = 5'd4;
        in_rs1_used = 1'b0;
        tick();
        in_pc       = 32'h114;
        in_load     = 1'b0;
        in_rd       = 5'd5;
        in_rs1      = 5'd1;
        in_rs1_used = 1'b1;
        in_rs2      = 5'd4;
        in_rs2_used = 1'b0;
        #1;
        chk("rs2u_haz", hazard_stall, 0);
        in_rs2_used = 1'b1;
        #1;
        chk("rs2_haz", hazard_stall, 1);
        in_rs2_used = 1'b0;
        #1;
        tick();
        chk("rs2u_pc", out_pc, 32'h114);
        chk("rs2u_valid", out_valid, 1);

        // hold 3 cycles with flush in the middle
        in_pc     = 32'h200;
        stall_vec = 4'b0100;
        #1;
        chk("hold_ready", in_ready, 0);
        tick();
        chk("hold1_pc", out_pc, 32'h114);
        chk("hold1_valid", out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hold2_valid", out_valid, 0);
        chk("hold2_wr", out_wr_reg, 0);
        chk("hold2_pc", out_pc, 32'h114);
        tick();
        chk("hold3_valid", out_valid, 0);
        chk("hold3_pc", out_pc, 32'h114);
`ifdef DE_EX_PERF_EN
        chk("hold_scnt", stall_cnt, 3);
`endif
        stall_vec = 4'b0000;
        #1;
        chk("unhold_ready", in_ready, 1);
        tick();
        chk("resume_pc", out_pc, 32'h200);
        chk("resume_valid", out_valid, 1);

        // flush versus capture
        in_pc     = 32'h300;
        in_rd     = 5'd6;
        in_wr_reg = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_wr", out_wr_reg, 0);
        chk("fl_pc", out_pc, 32'h200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/de_ex_pipe.md
# de_ex_pipe

Parametrised decode-to-execute pipeline register, successor to the fixed-width DE/EX flop bank. It sits between instruction decode and the execute stage. It latches the decoded operands, PC and packed control word with a valid bit. It also adds three things the fixed bank lacks: load-use interlock detection, priority-ordered flush, hold and bubble handling over a parametrised set of stall sources, and optional performance counters.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, operands and store data.
- CTRL_W, 24, width of the packed control word (mem_op, aluop, aluop_sub, csrop, MD_OP, mem_en, wr_mem, csr rd/wr bits).
- NSTALL, 4, number of downstream stall sources (de, mem, readram, mult).

Ports:
- clk  in  1  core clock; single clock domain.
- cpurst  in  1  reset; synchronous, active-high.
- in_valid  in  1  decode slot holds a real instruction.
- in_pc, in_op1, in_op2, in_wdata  in  XLEN each  decoded PC, operand 1, operand 2, store data.
- in_ctrl  in  CTRL_W  packed control word.
- in_load, in_wr_reg  in  1 each  instruction is a load / writes rd.
- in_rd, in_rs1, in_rs2  in  5 each  destination and source register indices.
- in_rs1_used, in_rs2_used  in  1 each  source is actually read.
- flush  in  1  kill the instruction entering execute (branch redirect).
- stall_vec  in  NSTALL  downstream stall requests; hold = OR of all bits.
- hazard_stall  out  1  combinational load-use interlock; decode and fetch freeze.
- in_ready  out  1  equals !hold & !hazard_stall; decode advances when high.
- out_valid, out_pc, out_op1, out_op2, out_wdata, out_ctrl, out_load, out_wr_reg, out_rd  out  registered mirrors of the corresponding inputs.
- bubble_cnt, stall_cnt  out  32 each  present only with DE_EX_PERF_EN.

## Operation
- Load-use hazard: hazard_stall = out_valid & out_load & out_wr_reg & in_valid & ((in_rs1_used & in_rs1==out_rd) | (in_rs2_used & in_rs2==out_rd)).
- out_rd==0 never creates a hazard, because out_wr_reg is never set for rd 0.
- Register update priority, evaluated each rising clk edge:
  1. cpurst: all outputs go to 0.
  2. flush: out_valid, out_wr_reg and out_load go to 0; the data fields keep their old values. Flush wins over hold.
  3. hold: all registers keep their values.
  4. hazard_stall: a bubble is inserted. out_valid, out_wr_reg and out_load go to 0; the data fields keep their values.
  5. Otherwise the stage captures its inputs:
     - out_valid = in_valid.
     - out_wr_reg = in_valid & in_wr_reg & (in_rd != 0).
     - out_load = in_valid & in_load.
- While out_valid = 0, out_wr_reg and out_load are always 0.
- A stalled instruction held in the register is not re-evaluated for hazards. Only the incoming slot is checked.
- Reset while held or while a bubble is pending clears everything. hazard_stall drops in the same cycle, since out_valid = 0.

## Timing
- Latency: 1 cycle from decode capture to the out_* ports.
- hazard_stall and in_ready are combinational from the registered out_* state plus the current inputs. There are no registered paths back to decode.
- A load-use pair costs exactly 1 bubble cycle when hold stays low throughout. If hold is asserted during the hazard, the bubble is deferred until hold drops.
- flush and hold in the same cycle: flush is applied.
- flush and hazard_stall in the same cycle: the flush clears the load, so the hazard disappears in the next cycle.
- Reset values: every output is 0, including both counters.

## Configuration
- Macro: DE_EX_PERF_EN.
- When defined, two 32-bit ports are added:
  - bubble_cnt increments on every cycle in which a bubble is inserted (priority 4).
  - stall_cnt increments on every cycle in which hold is high and cpurst is low.
  - Both saturate at 0xFFFFFFFF and are cleared only by cpurst.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

## Structure
- Package de_ex_pkg:
  - REG_IDX_W = 5 and the XLEN default.
  - Bit-position constants for the fields inside in_ctrl.
  - A packed struct typedef for the control word.
- One sub-module: de_ex_hazard, the combinational load-use comparator that produces hazard_stall.
- The register bank, priority logic and counters stay in de_ex_pipe.

## Test plan
- Reset: drive cpurst = 1 for 2 cycles with in_valid = 1 -> all outputs 0, in_ready = 1.
- Plain capture: in_pc = 0x100, in_op1 = 5, in_rd = 3, in_wr_reg = 1 -> next cycle out_pc = 0x100, out_op1 = 5, out_rd = 3, out_wr_reg = 1, out_valid = 1.
- Load-use: load with rd = 7, then an add with rs1 = 7 and rs1_used = 1 -> hazard_stall = 1 for one cycle and out_valid = 0 (bubble). The add is captured the cycle after, with bubble_cnt = 1.
- rd 0 and unused source:
  - load to rd = 0, then rs1 = 0 -> no hazard.
  - load to rd = 4, then rs2 = 4 with rs2_used = 0 -> no hazard.
- Hold: stall_vec = 4'b0100 for 3 cycles -> out_* frozen, in_ready = 0, stall_cnt = 3. flush in the middle cycle -> out_valid = 0 from the next cycle on.
- Flush versus capture: flush = 1 with in_valid = 1 -> out_valid = 0 and out_wr_reg = 0 the next cycle.
